pc_sequencer: RTL



---
 rtl/pc_sequencer.sv | 116 +++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the PC, fetches over a req/ack handshake, holds the word
// for execute until retire, then steps to PC+4 or PC+ImmOp, with halt/trap.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   imem_req/addr/ack/data instruction memory fetch handshake
//   instr/instr_pc/valid  word presented to execute; instr_ready retires it
//   PCsrc, ImmOp, halt    next-PC select, branch offset, stop request
//   PC, halted, misalign  program counter and terminal status
//   retired               retired-instruction counter

module pc_sequencer #(
  parameter int unsigned          WIDTH     = 32,
  parameter logic [WIDTH-1:0]     RESET_VEC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_data,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic             PCsrc,
  input  logic [WIDTH-1:0] ImmOp,
  input  logic             halt,
  output logic [WIDTH-1:0] PC,
  output logic             halted,
  output logic             misalign,
  output logic [WIDTH-1:0] retired
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] ipc_q, ipc_d;
  logic [WIDTH-1:0] ret_q, ret_d;
  logic             mis_q, mis_d;
  logic [WIDTH-1:0] target;

  assign target = pc_q + (PCsrc ? ImmOp : WIDTH'(4));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ret_d   = ret_q;
    mis_d   = mis_q;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_data;
          ipc_d   = pc_q;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (instr_ready) begin
          ret_d = ret_q + WIDTH'(1);
          // A bad target traps with PC left on the offending instruction.
          if (target[1:0] != 2'b00) begin
            mis_d   = 1'b1;
            state_d = S_HALT;
          end else begin
            pc_d    = target;
            state_d = halt ? S_HALT : S_FETCH;
          end
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_VEC;
      instr_q <= '0;
      ipc_q   <= '0;
      ret_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ret_q   <= ret_d;
      mis_q   <= mis_d;
    end
  end

  // Handshake strobes decode straight from the state register so that
  // reset drops them without waiting for a clock edge.
  assign imem_req    = (state_q == S_FETCH);
  assign instr_valid = (state_q == S_EXEC);
  assign halted      = (state_q == S_HALT);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign PC          = pc_q;
  assign misalign    = mis_q;
  assign retired     = ret_q;

endmodule
